calc_share_arbiter: RTL and testbench

- Shares one accumulator ALU between two independent requesters, A and B.
- The ALU supports four ops: add, reverse subtract, OR, equality compare.
- Each requester uses a level req/ack handshake. The block grants the ALU round-robin, executes one op against the shared accumulator, and holds Ack until the requester releases.
- Sits between the front-panel/host input logic and the accumulator datapath; it replaces the single-user Enter/WAIT sequencing.

---
 rtl/calc_pkg.sv | 17 +
 rtl/calc_alu.sv | 24 ++
 rtl/calc_share_arbiter.sv | 124 ++++++++++++
 tb/tb_calc_share_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the shared-accumulator calculator: ALU opcodes and arbiter states.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_RSUB = 2'b01,
        OP_OR   = 2'b10,
        OP_EQ   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        ACK  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational accumulator ALU: computes the next accumulator value from op, operand and current value.
module calc_alu
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] next_acc
);

    always_comb begin
        next_acc = '0;
        unique case (op)
            OP_ADD:  next_acc = num + acc;
            OP_RSUB: next_acc = num - acc;
            OP_OR:   next_acc = num | acc;
            OP_EQ:   next_acc = (num == acc) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
            default: next_acc = '0;
        endcase
    end

endmodule

// File: rtl/calc_share_arbiter.sv
// Round-robin arbiter sharing one accumulator ALU between requesters A and B
// over level req/ack handshakes.
module calc_share_arbiter
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             Reset_n,
    input  logic             ReqA,
    input  logic [1:0]       OpA,
    input  logic [WIDTH-1:0] NumA,
    output logic             AckA,
    input  logic             ReqB,
    input  logic [1:0]       OpB,
    input  logic [WIDTH-1:0] NumB,
    output logic             AckB,
    input  logic             Clear,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Owner
);

    arb_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic             owner_q, owner_d;
    logic             ptr_q, ptr_d;
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic             busy_q, busy_d;
    logic             grant_b;
    logic             owner_req;
    logic [WIDTH-1:0] alu_next;

    calc_alu #(.WIDTH(WIDTH)) u_alu (
        .op       (op_q),
        .num      (num_q),
        .acc      (acc_q),
        .next_acc (alu_next)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        op_d      = op_q;
        num_d     = num_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        busy_d    = 1'b1;
        grant_b   = ReqB && (!ReqA || ptr_q);
        owner_req = owner_q ? ReqB : ReqA;

        // Ack/Busy are registered, so they are computed for the state being entered.
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (Clear) begin
                    acc_d = '0;
                end else if (ReqA || ReqB) begin
                    owner_d = grant_b;
                    op_d    = grant_b ? op_e'(OpB) : op_e'(OpA);
                    num_d   = grant_b ? NumB : NumA;
                    state_d = EXEC;
                    busy_d  = 1'b1;
                end
            end
            EXEC: begin
                acc_d   = alu_next;
                state_d = ACK;
                ack_a_d = !owner_q;
                ack_b_d = owner_q;
            end
            ACK: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    ptr_d   = !owner_q;
                    busy_d  = 1'b0;
                end else begin
                    ack_a_d = !owner_q;
                    ack_b_d = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= OP_ADD;
            num_q   <= '0;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            num_q   <= num_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            busy_q  <= busy_d;
        end
    end

    assign AckA   = ack_a_q;
    assign AckB   = ack_b_q;
    assign Busy   = busy_q;
    assign Owner  = owner_q;
    assign Result = acc_q;

endmodule

// File: tb/tb_calc_share_arbiter.sv
// Directed plus randomized check of calc_share_arbiter against a transaction-level model.
module tb_calc_share_arbiter;

    localparam int unsigned WIDTH = 8;

    logic             clock = 1'b0;
    logic             Reset_n = 1'b0;
    logic             ReqA = 1'b0, ReqB = 1'b0, Clear = 1'b0;
    logic [1:0]       OpA = '0, OpB = '0;
    logic [WIDTH-1:0] NumA = '0, NumB = '0;
    logic             AckA, AckB, Busy, Owner;
    logic [WIDTH-1:0] Result;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] acc_m = '0;
    logic             ptr_m = 1'b0;

    calc_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .Reset_n (Reset_n),
        .ReqA    (ReqA),
        .OpA     (OpA),
        .NumA    (NumA),
        .AckA    (AckA),
        .ReqB    (ReqB),
        .OpB     (OpB),
        .NumB    (NumB),
        .AckB    (AckB),
        .Clear   (Clear),
        .Result  (Result),
        .Busy    (Busy),
        .Owner   (Owner)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] alu_ref(input logic [1:0] op, input logic [WIDTH-1:0] n,
                                                 input logic [WIDTH-1:0] a);
        int unsigned s;
        case (op)
            2'd0: s = (int'(n) + int'(a)) % 256;
            2'd1: s = (256 + int'(n) - int'(a)) % 256;
            2'd2: s = int'(n | a);
            default: s = (n == a) ? 1 : 0;
        endcase
        return s[WIDTH-1:0];
    endfunction

    // Wait for the given requester's ack, check the outcome against the model, then release.
    task automatic serve(input logic who, input logic [1:0] op, input logic [WIDTH-1:0] n,
                         input string tag);
        int cyc = 0;
        while (((who ? AckB : AckA) !== 1'b1) && cyc < 12) begin
            step();
            cyc++;
        end
        check({tag, "_ack"}, {31'd0, who ? AckB : AckA}, 32'd1);
        acc_m = alu_ref(op, n, acc_m);
        check({tag, "_result"}, {24'd0, Result}, {24'd0, acc_m});
        check({tag, "_owner"}, {31'd0, Owner}, {31'd0, who});
        check({tag, "_other_ack"}, {31'd0, who ? AckA : AckB}, 32'd0);
        if (who) ReqB = 1'b0; else ReqA = 1'b0;
        ptr_m = !who;
        step();
        check({tag, "_ack_drop"}, {31'd0, who ? AckB : AckA}, 32'd0);
    endtask

    // Raise one or both requests in the same IDLE cycle and serve them in model order.
    task automatic txn(input logic a_on, input logic b_on, input string tag);
        logic first;
        logic [1:0] oa, ob;
        logic [WIDTH-1:0] na, nb;
        oa = OpA; ob = OpB; na = NumA; nb = NumB;
        first = (a_on && b_on) ? ptr_m : !a_on;
        ReqA = a_on;
        ReqB = b_on;
        serve(first, first ? ob : oa, first ? nb : na, {tag, "_1st"});
        if (a_on && b_on)
            serve(!first, first ? oa : ob, first ? na : nb, {tag, "_2nd"});
        check({tag, "_idle"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        Reset_n = 1'b0;
        step();
        check("rst_result", {24'd0, Result}, 32'd0);
        check("rst_acka", {31'd0, AckA}, 32'd0);
        check("rst_ackb", {31'd0, AckB}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_owner", {31'd0, Owner}, 32'd0);
        Reset_n = 1'b1;
        step();

        // A adds 5, checking the exact handshake latency.
        OpA = 2'b00; NumA = 8'd5; ReqA = 1'b1;
        step();
        check("t1_exec_busy", {31'd0, Busy}, 32'd1);
        check("t1_exec_ack", {31'd0, AckA}, 32'd0);
        step();
        check("t1_ack", {31'd0, AckA}, 32'd1);
        check("t1_result", {24'd0, Result}, 32'd5);
        check("t1_owner", {31'd0, Owner}, 32'd0);
        ReqA = 1'b0;
        step();
        check("t1_ack_drop", {31'd0, AckA}, 32'd0);
        check("t1_busy_drop", {31'd0, Busy}, 32'd0);
        acc_m = 8'd5; ptr_m = 1'b1;

        OpB = 2'b01; NumB = 8'd3;
        txn(1'b0, 1'b1, "t2_rsub");
        check("t2_wrap", {24'd0, Result}, 32'hFE);

        OpA = 2'b10; NumA = 8'h01; OpB = 2'b11; NumB = 8'hFF;
        txn(1'b1, 1'b1, "t3_pair");
        check("t3_eq", {24'd0, Result}, 32'd1);
        OpA = 2'b00; NumA = 8'd2;
        txn(1'b1, 1'b0, "t3_solo");
        OpA = 2'b00; NumA = 8'd4; OpB = 2'b00; NumB = 8'd6;
        check("t3_ptr_b", {31'd0, ptr_m}, 32'd1);
        txn(1'b1, 1'b1, "t3_pair_b_first");

        // Clear beats a same-cycle request; grant follows one cycle later.
        Clear = 1'b1; ReqA = 1'b1; OpA = 2'b00; NumA = 8'd7;
        step();
        Clear = 1'b0;
        acc_m = '0;
        check("clr_result", {24'd0, Result}, 32'd0);
        check("clr_no_grant", {31'd0, Busy}, 32'd0);
        step();
        check("clr_grant", {31'd0, Busy}, 32'd1);
        NumA = 8'd9;
        step();
        check("latch_result", {24'd0, Result}, 32'd7);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        check("clr_in_ack", {24'd0, Result}, 32'd7);
        serve(1'b0, 2'b00, 8'd7, "latch");

        // Async reset during ACK.
        OpA = 2'b00; NumA = 8'd11; ReqA = 1'b1;
        step();
        step();
        check("pre_rst_ack", {31'd0, AckA}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("mid_rst_acka", {31'd0, AckA}, 32'd0);
        check("mid_rst_result", {24'd0, Result}, 32'd0);
        check("mid_rst_busy", {31'd0, Busy}, 32'd0);
        ReqA = 1'b0;
        acc_m = '0; ptr_m = 1'b0;
        step();
        Reset_n = 1'b1;
        OpB = 2'b00; NumB = 8'd3;
        txn(1'b0, 1'b1, "post_rst_b");
        OpA = 2'b00; NumA = 8'd1;
        txn(1'b1, 1'b0, "post_rst_a");
        // Pointer now prefers B; reset must bring it back to A.
        Reset_n = 1'b0;
        #1;
        Reset_n = 1'b1;
        acc_m = '0; ptr_m = 1'b0;
        step();
        OpA = 2'b00; NumA = 8'd20; OpB = 2'b00; NumB = 8'd30;
        txn(1'b1, 1'b1, "rst_ptr");

        for (int i = 0; i < 30; i++) begin
            logic a_on, b_on;
            a_on = 1'($urandom_range(0, 1));
            b_on = 1'($urandom_range(0, 1));
            if (!a_on && !b_on) a_on = 1'b1;
            OpA = 2'($urandom); NumA = 8'($urandom);
            OpB = 2'($urandom); NumB = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                Clear = 1'b1;
                step();
                Clear = 1'b0;
                acc_m = '0;
            end
            txn(a_on, b_on, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
